// File: rtl/wb_rr_arbiter_pkg.sv
// Shared encodings for the round-robin result-path arbiter.
package wb_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } st_t;

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_MDU  = 2'd2;
    localparam logic [1:0] SRC_LINK = 2'd3;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Requester/sink bundle: four source words in, one registered word out.
interface wb_rr_arbiter_if #(parameter int WIDTH = 32);
    logic [3:0]       req;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] in_d;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output req, in_a, in_b, in_c, in_d, out_ready,
        input  gnt, out_data, out_src, out_valid
    );

    modport slave (
        input  req, in_a, in_b, in_c, in_d, out_ready,
        output gnt, out_data, out_src, out_valid
    );
endinterface

// File: rtl/wb_rr_arbiter_mux.sv
// 4:1 word steering, indexed by the source-number constants.
module Mux4_1
    import wb_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = a;
        case (sel)
            SRC_ALU:  y = a;
            SRC_MEM:  y = b;
            SRC_MDU:  y = c;
            SRC_LINK: y = d;
            default:  y = a;
        endcase
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Bounded-burst round-robin arbiter feeding a single registered output stage.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_rr_arbiter_if.slave bus
);
    st_t              st, nxt;
    logic [1:0]       ptr, own, scan_w, w, idx;
    logic [3:0]       cnt;
    logic             load, keep, acc, found;
    logic [WIDTH-1:0] mux_y;

    assign load = !bus.out_valid || bus.out_ready;
    assign keep = (st == ST_BURST) && bus.req[own] && (cnt < 4'(MAX_BURST));
    assign w    = keep ? own : scan_w;
    // rst_n gates the accept so gnt reads 0 while reset is held
    assign acc  = rst_n && load && (|bus.req);
    assign bus.gnt = acc ? (4'b0001 << w) : 4'b0000;

    always_comb begin
        scan_w = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req[idx]) begin
                scan_w = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        nxt = st;
        if (acc)
            nxt = ST_BURST;
        else if (load)
            nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= nxt;
    end

    Mux4_1 #(.WIDTH(WIDTH)) u_mux (
        .sel (w),
        .a   (bus.in_a),
        .b   (bus.in_b),
        .c   (bus.in_c),
        .d   (bus.in_d),
        .y   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            bus.out_valid <= 1'b0;
            ptr           <= '0;
            own           <= '0;
            cnt           <= '0;
        end else if (acc) begin
            bus.out_data  <= mux_y;
            bus.out_src   <= w;
            bus.out_valid <= 1'b1;
            ptr           <= w + 2'd1;
            own           <= w;
            cnt           <= keep ? cnt + 4'd1 : 4'd1;
        end else if (load) begin
            // nothing requested: either the held word drains or there was none
            bus.out_valid <= 1'b0;
            cnt           <= '0;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench: stimulus pushes expected words, a monitor pops them at each handshake.
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   stepno = 0;
    int   held_step;
    logic [33:0] q[$];

    wb_rr_arbiter_if #(.WIDTH(32)) bus ();

    wb_rr_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // inputs are driven just after a rising edge; ec < 0 skips the cnt check
    task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] eg, input int ec);
        logic [1:0] s;
        stepno++;
        bus.req       = r;
        bus.out_ready = rdy;
        bus.in_a      = 32'h1000_0000 + 32'(stepno);
        bus.in_b      = 32'h2000_0000 + 32'(stepno);
        bus.in_c      = 32'h3000_0000 + 32'(stepno);
        bus.in_d      = 32'h4000_0000 + 32'(stepno);
        @(negedge clk);
        chk($sformatf("gnt step%0d", stepno), 32'(bus.gnt), 32'(eg));
        if (eg != 4'b0000) begin
            s = oh2idx(eg);
            q.push_back({s, 32'(s + 1) << 28 | 32'(stepno)});
        end
        @(posedge clk);
        #1;
        if (ec >= 0) chk($sformatf("cnt step%0d", stepno), 32'(dut.cnt), 32'(ec));
    endtask

    // monitor: a word present with out_ready high is consumed at the next edge
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL word: actual=%0d/%h required=no word", bus.out_src, bus.out_data);
                end else begin
                    e = q.pop_front();
                    if ({bus.out_src, bus.out_data} !== e) begin
                        bad++;
                        $display("FAIL word: actual=%0d/%h required=%0d/%h",
                                 bus.out_src, bus.out_data, e[33:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.req = 4'b1111;
        bus.out_ready = 1'b1;
        bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
        @(negedge clk);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_data",  bus.out_data,       32'd0);
        chk("rst out_src",   32'(bus.out_src),   32'd0);
        chk("rst gnt",       32'(bus.gnt),       32'd0);
        @(posedge clk);
        #1;
        bus.req = 4'b0000;
        rst_n = 1'b1;

        // full contention: four beats per owner, then rotate
        for (int i = 0; i < 17; i++)
            step(4'b1111, 1'b1, 4'b0001 << ((i / 4) % 4), (i % 4) + 1);
        held_step = stepno;

        // backpressure: held word stays put, no grants
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 1'b0, 4'b0000, 1);
            chk("bp out_data",  bus.out_data, 32'h1000_0000 + 32'(held_step));
            chk("bp out_valid", 32'(bus.out_valid), 32'd1);
        end
        step(4'b0011, 1'b1, 4'b0001, 2);
        step(4'b0011, 1'b1, 4'b0001, 3);
        step(4'b0011, 1'b1, 4'b0001, 4);
        step(4'b0011, 1'b1, 4'b0010, 1);

        // idle drain
        step(4'b0000, 1'b1, 4'b0000, 0);
        chk("drain out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain state",     32'(dut.st),        32'(ST_IDLE));
        chk("drain ptr",       32'(dut.ptr),       32'd2);

        // single requester keeps re-winning with burst restarts
        for (int i = 0; i < 10; i++)
            step(4'b0100, 1'b1, 4'b0100, (i % 4) + 1);
        chk("single out_src", 32'(bus.out_src), 32'd2);

        // reset mid-burst with a word held
        bus.req = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("rst2 out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2 out_data",  bus.out_data,       32'd0);
        chk("rst2 out_src",   32'(bus.out_src),   32'd0);
        chk("rst2 gnt",       32'(bus.gnt),       32'd0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1111, 1'b1, 4'b0001, 1);

        // early release: owner 0 drops after two beats
        step(4'b1001, 1'b1, 4'b0001, 2);
        step(4'b1000, 1'b1, 4'b1000, 1);
        chk("early ptr", 32'(dut.ptr), 32'd0);

        step(4'b0000, 1'b1, 4'b0000, 0);
        step(4'b0000, 1'b1, 4'b0000, 0);
        chk("queue empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
